// File: rtl/mux2_reg.sv
// Two-input WIDTH-bit multiplexer with a live combinational output and a
// one-cycle registered copy for downstream timing closure.
module mux2_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q
);

  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_y_q;

  // The conditional operator merges a and b bitwise on an unknown select,
  // giving gate-level consensus: equal bits pass through, differing bits go X.
  assign w_y = s ? b : a;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y_q <= '0;
    end else begin
      r_y_q <= w_y;
    end
  end

  assign y   = w_y;
  assign y_q = r_y_q;

endmodule

// File: tb/tb_mux2_reg.sv
// Directed and random checks of mux2_reg at WIDTH 1, 8 and 32 on a shared
// clock and reset; registered output checked against a queue of expectations.
module tb_mux2_reg;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a1, b1, s1;
  logic        y1, yq1;
  logic [7:0]  a8, b8;
  logic        s8;
  logic [7:0]  y8, yq8;
  logic [31:0] a32, b32;
  logic        s32;
  logic [31:0] y32, yq32;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  mux2_reg #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .s(s1), .y(y1), .y_q(yq1)
  );
  mux2_reg #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .s(s8), .y(y8), .y_q(yq8)
  );
  mux2_reg #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .s(s32), .y(y32), .y_q(yq32)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive1(input logic a, input logic b, input logic s);
    a1 = a;
    b1 = b;
    s1 = s;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_y;
    logic [31:0] exp_reg;
    logic        probe_x;

    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; s1 = 1'b0;
    a8 = '0;   b8 = '0;   s8 = 1'b0;
    a32 = '0;  b32 = '0;  s32 = 1'b0;

    // Reset state
    tick();
    check("rst_yq1", {31'b0, yq1}, 32'h0);
    check("rst_yq8", {24'b0, yq8}, 32'h0);
    check("rst_yq32", yq32, 32'h0);
    a8 = 8'hA5;
    #1;
    check("y_live_in_reset", {24'b0, y8}, 32'h0000_00A5);
    @(negedge clk);
    rst_n = 1'b1;

    // s=0 sweep: y follows a
    drive1(1'b0, 1'b0, 1'b0); check("s0_ab00", {31'b0, y1}, 32'd0);
    drive1(1'b0, 1'b1, 1'b0); check("s0_ab01", {31'b0, y1}, 32'd0);
    drive1(1'b1, 1'b0, 1'b0); check("s0_ab10", {31'b0, y1}, 32'd1);
    drive1(1'b1, 1'b1, 1'b0); check("s0_ab11", {31'b0, y1}, 32'd1);

    // s=1 sweep: y follows b
    drive1(1'b0, 1'b0, 1'b1); check("s1_ab00", {31'b0, y1}, 32'd0);
    drive1(1'b0, 1'b1, 1'b1); check("s1_ab01", {31'b0, y1}, 32'd1);
    drive1(1'b1, 1'b0, 1'b1); check("s1_ab10", {31'b0, y1}, 32'd0);
    drive1(1'b1, 1'b1, 1'b1); check("s1_ab11", {31'b0, y1}, 32'd1);

    // Select toggle with a=1, b=0
    drive1(1'b1, 1'b0, 1'b0); check("tog_s0", {31'b0, y1}, 32'd1);
    drive1(1'b1, 1'b0, 1'b1); check("tog_s1", {31'b0, y1}, 32'd0);

    // Registered path
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'hC3; s8 = 1'b0;
    tick();
    check("reg_5a", {24'b0, yq8}, 32'h0000_005A);
    @(negedge clk);
    a8 = 8'hFF;
    #1;
    check("reg_hold", {24'b0, yq8}, 32'h0000_005A);
    check("comb_ff", {24'b0, y8}, 32'h0000_00FF);
    s8 = 1'b1;
    #1;
    check("comb_c3", {24'b0, y8}, 32'h0000_00C3);
    check("reg_hold2", {24'b0, yq8}, 32'h0000_005A);
    tick();
    check("reg_c3", {24'b0, yq8}, 32'h0000_00C3);

    // Synchronous reset mid-operation
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("srst_before_edge", {24'b0, yq8}, 32'h0000_00C3);
    check("srst_y_before", {24'b0, y8}, 32'h0000_00C3);
    tick();
    check("srst_after_edge", {24'b0, yq8}, 32'h0000_0000);
    check("srst_y_after", {24'b0, y8}, 32'h0000_00C3);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("srst_release_hold", {24'b0, yq8}, 32'h0000_0000);
    tick();
    check("srst_reload", {24'b0, yq8}, 32'h0000_00C3);

    // Unknown select: consensus on equal inputs
    drive1(1'b1, 1'b1, 1'bx); check("xsel_11", {31'b0, y1}, 32'd1);
    drive1(1'b0, 1'b0, 1'bx); check("xsel_00", {31'b0, y1}, 32'd0);
    drive1(1'b0, 1'b1, 1'bx);
    probe_x = 1'bx;
    if (probe_x === 1'bx) begin
      check("xsel_01", {31'b0, y1}, {31'b0, 1'bx});
    end
    s1 = 1'b0;

    // Random regression on the 32-bit instance
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a32   = $urandom;
      b32   = $urandom;
      s32   = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 7) != 0);
      if (s32) exp_y = b32;
      else     exp_y = a32;
      exp_reg = rst_n ? exp_y : 32'h0;
      exp_q.push_back(exp_reg);
      #1;
      check("rnd_y", y32, exp_y);
      tick();
      check("rnd_yq", yq32, exp_q.pop_front());
    end

    // Final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mux2_reg.md
Name: mux2_reg

Overview:
- Two-input multiplexer with select `s`.
- Provides a zero-latency combinational output `y`.
- Provides a one-cycle registered copy `y_q` for timing-closure use downstream.
- Leaf datapath primitive used wherever two same-width sources are steered to one sink, with an optional pipeline stage.

Parameters:
WIDTH  1  bit width of a, b, y, y_q; legal range 1..64.

Ports:
clk    input   1      rising-edge clock for the output register
rst_n  input   1      synchronous reset, active-low
y      output  WIDTH  combinational mux output
a      input   WIDTH  data input 0, selected when s=0
b      input   WIDTH  data input 1, selected when s=1
s      input   1      select
y_q    output  WIDTH  registered mux output (y delayed one clk)

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. rst_n is sampled only on the rising edge of clk, with no asynchronous path.
- Combinational path:
  - y = a when s=0; y = b when s=1.
  - Zero latency; no dependence on clk or rst_n.
  - y follows any change on a, b or s in the same delta/time step.
- Bitwise rule: each bit y[i] depends only on a[i], b[i] and s. No arithmetic, no width extension; all data ports are exactly WIDTH bits.
- Unknown select:
  - If s is X/Z and a[i]==b[i], then y[i]=a[i].
  - Otherwise y[i]=X.
  - This matches gate-level mux consensus behaviour.
- Registered path:
  - At each rising clk edge: if rst_n=0 then y_q <= 0 (all bits), else y_q <= (s ? b : a) sampled at that edge.
  - Latency is exactly 1 clk from input change to y_q.
- Reset values:
  - y_q = all-zero after any clk edge with rst_n=0.
  - y is not reset; it is always the live mux of current inputs, even while rst_n=0.
- Reset mid-operation: asserting rst_n=0 for one edge clears y_q on that edge. The first edge with rst_n=1 loads the current mux value.
- Before the first clk edge, y_q is undefined (X in simulation). No initial-value dependence is permitted.
- Simultaneous a/b/s changes coincident with a clk edge: y_q captures the values settled before the edge (standard setup semantics; the bench drives inputs away from edges).
- No internal state other than the WIDTH-bit y_q register. No handshake, no enable, no FSM.

Test Plan:
1. WIDTH=1, s=0, sweep (a,b) = 00, 01, 10, 11 at 1 ns steps -> y = 0, 0, 1, 1 immediately after each step.
2. WIDTH=1, s=1, sweep (a,b) = 00, 01, 10, 11 -> y = 0, 1, 0, 1; toggling s with a=1, b=0 flips y 1->0 with zero delay.
3. Registered path, WIDTH=8, rst_n=1:
   - a=8'h5A, b=8'hC3, s=0 -> y_q=8'h5A after next edge.
   - s=1 -> y_q=8'hC3 one edge later.
   - y_q unchanged between edges.
4. Sync reset, WIDTH=8, y_q=8'hC3:
   - Drop rst_n=0 between edges -> y_q stays 8'hC3 until the next rising edge, then 8'h00.
   - y still shows 8'hC3 throughout.
   - Release rst_n -> next edge y_q=8'hC3.
5. X select, WIDTH=1, s=X:
   - a=b=1 -> y=1.
   - a=b=0 -> y=0.
   - a=0, b=1 -> y=X.
6. Random regression, WIDTH=32, 1000 cycles of random a/b/s/rst_n:
   - y == (s ? b : a) at every sample.
   - y_q equals the previous cycle's expected value, or 0 if the previous-edge rst_n was 0.
